// File: rtl/float_recip_seq.sv
// Multi-cycle reciprocal z = 1/x for a 16-bit float (1/8/7, bias 127) using a restoring divider.
// Define FLOAT_RECIP_ROUND_EN to round to nearest on the guard bit; otherwise the result truncates.
module float_recip_seq #(
  parameter int unsigned QBITS    = 9,
  parameter int unsigned EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x,
  output logic        ready,
  output logic        done,
  output logic [15:0] z,
  output logic        div_zero
);

`ifdef FLOAT_RECIP_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StDiv, StPack} state_t;

  state_t           state_q;
  logic             s_q;
  logic [7:0]       e_q;
  logic [7:0]       m_q;
  logic [QBITS-1:0] rem_q;
  logic [QBITS-1:0] q_q;
  logic [3:0]       cnt_q;

  logic [QBITS-1:0] rem_shift;
  logic [QBITS-1:0] rem_next;
  logic             q_bit;

  logic [8:0]  exp_special;
  logic [8:0]  exp_norm;
  logic [8:0]  exp_r;
  logic [8:0]  exp_sel;
  logic [6:0]  frac_r;
  logic [6:0]  frac_sel;
  logic        guard;
  logic        carry;
  logic [15:0] z_pack;
  logic        dz_pack;

  // Remainder is always below M (< 256), so the doubled value still fits in 9 bits.
  always_comb begin
    rem_shift = {rem_q[QBITS-2:0], 1'b0};
    q_bit     = (rem_shift >= {1'b0, m_q});
    rem_next  = q_bit ? (rem_shift - {1'b0, m_q}) : rem_shift;
  end

  always_comb begin
    exp_special = 9'(2 * EXP_BIAS) - {1'b0, e_q};
    exp_norm    = exp_special - 9'd1;
    guard       = RoundEn ? q_q[0] : 1'b0;
    {carry, frac_r} = {1'b0, q_q[7:1]} + {7'b0, guard};
    exp_r       = exp_norm + {8'b0, carry};
    exp_sel     = exp_r;
    frac_sel    = frac_r;
    z_pack      = 16'h0000;
    dz_pack     = 1'b0;
    if (e_q == 8'd0) begin
      z_pack  = {s_q, 8'hFF, 7'h00};
      dz_pack = 1'b1;
    end else begin
      // M = 128 gives Q = 512, which does not fit the quotient register.
      if (m_q[6:0] == 7'd0) begin
        exp_sel  = exp_special;
        frac_sel = 7'd0;
      end
      if (!exp_sel[8] && (exp_sel != 9'd0)) begin
        z_pack = {s_q, exp_sel[7:0], frac_sel};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      s_q      <= 1'b0;
      e_q      <= 8'd0;
      m_q      <= 8'd0;
      rem_q    <= '0;
      q_q      <= '0;
      cnt_q    <= 4'd0;
      ready    <= 1'b1;
      done     <= 1'b0;
      z        <= 16'h0000;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            s_q     <= x[15];
            e_q     <= x[14:7];
            m_q     <= {1'b1, x[6:0]};
            // Dividend bits above Q[8] leave 2^16 >> 9 = 128 as the starting remainder.
            rem_q   <= QBITS'(128);
            q_q     <= '0;
            cnt_q   <= 4'(QBITS - 1);
            ready   <= 1'b0;
            state_q <= StDiv;
          end
        end
        StDiv: begin
          rem_q <= rem_next;
          q_q   <= {q_q[QBITS-2:0], q_bit};
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_q <= StPack;
        end
        StPack: begin
          z        <= z_pack;
          div_zero <= dz_pack;
          done     <= 1'b1;
          ready    <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
